unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RISC-V core.
- Sits between the two stage interfaces and the memory macro.
- Sequences each access through a small FSM and returns per-requester valid/stall so the hazard logic can freeze the pipeline.
- Honours the control unit's `flush_if` so a fetch cancelled by a taken branch or jump never delivers an instruction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles after the enable cycle; legal 1..7
- CNT_W, 3, latency counter width; must hold MEM_LAT

Ports:
- clk  in  1  single clock, rising edge
- arst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- flush_if  in  1  cancel the in-flight or completing fetch
- if_valid  out  1  one-cycle pulse: if_rdata holds the fetched instruction
- if_rdata  out  DATA_W  last fetched word (registered)
- if_stall  out  1  if_req pending and not completing this cycle
- dm_read  in  1  load request; held until dm_valid
- dm_write  in  1  store request; held until dm_valid
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_valid  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DATA_W  last loaded word (registered)
- dm_stall  out  1  data request pending and not completing this cycle
- m_en  out  1  memory enable, exactly one cycle per access (registered)
- m_we  out  1  memory write enable, valid with m_en (registered)
- m_addr  out  ADDR_W  memory address (registered)
- m_wdata  out  DATA_W  memory write data (registered)
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_en

## Operation
- States:
  - IDLE: arbitrate.
  - WAIT: access in flight; cnt counts 0..MEM_LAT.
  - DONE: deliver result for one cycle.
- IDLE:
  - dm_read|dm_write takes priority over if_req, because the MEM-stage instruction is older.
  - The winner is recorded as owner (IF/DM), followed by a transition to WAIT.
  - The next cycle drives m_en=1, m_addr and m_we (=dm_write); m_wdata is driven for writes only.
  - cnt is reset to 0.
- WAIT:
  - m_en=0 after the first cycle; cnt increments each cycle.
  - When cnt==MEM_LAT: for a read, capture m_rdata into if_rdata or dm_rdata by owner, then go to DONE.
  - Writes also wait the full MEM_LAT and leave dm_rdata unchanged.
- DONE:
  - Pulse the owner's valid, unless the owner is IF and the drop flag is set.
  - Always go to IDLE; no back-to-back issue.
- Stall: if_stall = if_req & ~(DONE & owner==IF & ~drop); dm_stall = (dm_read|dm_write) & ~(DONE & owner==DM).
- flush_if:
  - In WAIT or DONE with owner IF, set drop. The memory access still runs to completion; if_rdata is still updated, but if_valid=0 and if_stall stays 1.
  - drop clears on entering IDLE.
  - In IDLE, flush_if has no effect.
  - With owner DM, flush_if is ignored.
- dm_read & dm_write both high: treated as a write.
- Requests dropped by a requester before valid: the access completes internally, and valid is pulsed only if the request is still high in DONE.

## Timing
- Access cycle:
  - request seen in IDLE at cycle t
  - m_en at t+1
  - m_rdata sampled at t+1+MEM_LAT
  - valid at t+2+MEM_LAT
  - IDLE at t+3+MEM_LAT
- Occupancy: MEM_LAT+3 cycles per access; a losing requester waits the full occupancy.
- Reset values:
  - state = IDLE, owner = IF, drop = 0, cnt = 0.
  - m_en, m_we, m_addr, m_wdata, if_rdata, dm_rdata, if_valid and dm_valid are all 0.
  - Stalls equal their requests.
- Reset mid-access: immediate return to IDLE with m_en=0. The in-flight read is discarded and no valid is pulsed.

## Structure
- Shared package:
  - arb_state_t enum (IDLE, WAIT, DONE)
  - owner encoding (OWN_IF, OWN_DM)
- Sub-module arb_wait_counter (load, enable, done when value==MEM_LAT) instantiated once.
- The FSM and output registers live in the top module.

## Test plan
- Reset, then fetch only: if_req=1, if_addr=0x40, MEM_LAT=2, memory returns 0x00500093 -> m_en at t+1 with m_addr=0x40, if_valid at t+4 with if_rdata=0x00500093, if_stall high for cycles t..t+3.
- Simultaneous requests in IDLE: if_req and dm_read (addr 0x100, data 0xDEADBEEF) -> DM served first with dm_valid at t+4, then IF issues at t+6 with if_valid at t+9.
- Store: dm_write, addr 0x104, wdata 0x12345678 -> one m_en cycle with m_we=1, dm_valid at t+4, dm_rdata unchanged.
- flush_if in WAIT of a fetch at 0x40 -> no if_valid and if_stall held. After IDLE, the new if_addr=0x80 is issued and completes normally.
- arst_n low during WAIT -> all outputs at reset values within the same cycle, and no valid after release.
- MEM_LAT=1 and MEM_LAT=7 builds -> valid exactly MEM_LAT+2 cycles after the request.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the IF/MEM unified memory arbiter: FSM states and access owner.
package unified_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;
endpackage

// File: rtl/arb_wait_counter.sv
// Counts cycles of an in-flight memory access; o_done flags the cycle read data is valid.
module arb_wait_counter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == CNT_W'(MEM_LAT));
endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and load/store.
// One access at a time (MEM_LAT+3 cycles); data side wins ties; flush_if suppresses a fetch result.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_if,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    arb_state_t        r_state, w_state_nxt;
    arb_owner_t        r_owner, w_owner_nxt;
    logic              r_drop, r_wr;
    logic              r_m_en, r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata, r_if_rdata, r_dm_rdata;
    logic              w_dm_req, w_issue, w_cnt_load, w_cnt_en, w_cnt_done;
    logic              w_capture, w_drop, w_if_done, w_dm_done;

    assign w_dm_req = dm_read | dm_write;

    arb_wait_counter #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) u_wait_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .i_load (w_cnt_load),
        .i_en   (w_cnt_en),
        .o_done (w_cnt_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_issue     = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_load = 1'b1;
                // The MEM-stage instruction is older, so it goes first.
                if (w_dm_req) begin
                    w_owner_nxt = OWN_DM;
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end else if (if_req) begin
                    w_owner_nxt = OWN_IF;
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_cnt_en = 1'b1;
                if (w_cnt_done) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_IF;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign w_capture = (r_state == WAIT) & w_cnt_done & ~r_wr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_wr       <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_m_en <= w_issue;
            r_m_we <= w_issue & w_dm_req & dm_write;
            if (w_issue) begin
                r_m_addr <= w_dm_req ? dm_addr : if_addr;
                r_wr     <= w_dm_req & dm_write;
            end
            if (w_issue & w_dm_req & dm_write) r_m_wdata <= dm_wdata;
            if (w_capture && r_owner == OWN_IF) r_if_rdata <= m_rdata;
            if (w_capture && r_owner == OWN_DM) r_dm_rdata <= m_rdata;
            // A cancelled fetch still finishes in memory; only its delivery is suppressed.
            if (r_state == DONE) begin
                r_drop <= 1'b0;
            end else if (r_state == WAIT && r_owner == OWN_IF && flush_if) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign w_drop    = r_drop | (flush_if & (r_owner == OWN_IF) & (r_state != IDLE));
    assign w_if_done = (r_state == DONE) & (r_owner == OWN_IF) & ~w_drop;
    assign w_dm_done = (r_state == DONE) & (r_owner == OWN_DM);

    assign if_valid = w_if_done & if_req;
    assign dm_valid = w_dm_done & w_dm_req;
    assign if_stall = if_req & ~w_if_done;
    assign dm_stall = w_dm_req & ~w_dm_done;
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;
    assign m_en     = r_m_en;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table plus hand-written corner sequences.
module tb_unified_mem_arbiter;
    localparam int LAT = 2;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mreq_t;
    typedef struct { logic is_dm; logic [31:0] data; } rsp_t;
    typedef struct {
        int kind; logic [31:0] addr; logic [31:0] wdata;
        int flush_at; logic [31:0] exp_rdata; int exp_lat;
    } vec_t;

    logic        clk = 1'b0, arst_n = 1'b0;
    logic        if_req = 1'b0, flush_if = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic        if_valid, if_stall, dm_valid, dm_stall, m_en, m_we;
    logic [31:0] if_rdata, dm_rdata, m_addr, m_wdata, m_rdata;

    logic        l1_req = 1'b0, l7_req = 1'b0;
    logic        l1_valid, l1_stall, l1_dvalid, l1_dstall, l1_en, l1_we;
    logic        l7_valid, l7_stall, l7_dvalid, l7_dstall, l7_en, l7_we;
    logic [31:0] l1_rdata, l1_drdata, l1_addr, l1_wdata, l1_mrdata;
    logic [31:0] l7_rdata, l7_drdata, l7_addr, l7_wdata, l7_mrdata;

    int checks = 0, failures = 0, cyc = 0, last_men = -1;
    mreq_t mreq_q[$];
    rsp_t  rsp_q[$];
    logic [31:0] exp_dm = '0;
    logic [31:0] p2 [8], p1 [8], p7 [8];
    vec_t vecs [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(3)) dut (
        .clk(clk), .arst_n(arst_n), .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata));

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CNT_W(3)) u_l1 (
        .clk(clk), .arst_n(arst_n), .if_req(l1_req), .if_addr(32'h40), .flush_if(1'b0),
        .if_valid(l1_valid), .if_rdata(l1_rdata), .if_stall(l1_stall),
        .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_valid(l1_dvalid), .dm_rdata(l1_drdata), .dm_stall(l1_dstall),
        .m_en(l1_en), .m_we(l1_we), .m_addr(l1_addr), .m_wdata(l1_wdata), .m_rdata(l1_mrdata));

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(7), .CNT_W(3)) u_l7 (
        .clk(clk), .arst_n(arst_n), .if_req(l7_req), .if_addr(32'h40), .flush_if(1'b0),
        .if_valid(l7_valid), .if_rdata(l7_rdata), .if_stall(l7_stall),
        .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_valid(l7_dvalid), .dm_rdata(l7_drdata), .dm_stall(l7_dstall),
        .m_en(l7_en), .m_we(l7_we), .m_addr(l7_addr), .m_wdata(l7_wdata), .m_rdata(l7_mrdata));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h00500093;
            32'h100: return 32'hDEADBEEF;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        endcase
    endfunction

    // Memory model: read data appears exactly MEM_LAT cycles after the enable cycle.
    always @(posedge clk) begin
        p2[0] <= (m_en && !m_we) ? mem_word(m_addr) : 32'hBAD0BAD0;
        p1[0] <= (l1_en && !l1_we) ? mem_word(l1_addr) : 32'hBAD0BAD0;
        p7[0] <= (l7_en && !l7_we) ? mem_word(l7_addr) : 32'hBAD0BAD0;
        for (int i = 1; i < 8; i++) begin
            p2[i] <= p2[i-1];
            p1[i] <= p1[i-1];
            p7[i] <= p7[i-1];
        end
    end
    assign m_rdata   = p2[LAT-1];
    assign l1_mrdata = p1[0];
    assign l7_mrdata = p7[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: memory-side issue and requester-side delivery popped as the DUT produces them.
    always @(negedge clk) begin
        mreq_t e;
        rsp_t  r;
        if (m_en) begin
            last_men = cyc;
            if (mreq_q.size() == 0) begin
                chk("m_en_unexpected", 32'(m_en), 32'h0);
            end else begin
                e = mreq_q.pop_front();
                chk("m_we", 32'(m_we), 32'(e.we));
                chk("m_addr", m_addr, e.addr);
                if (e.we) chk("m_wdata", m_wdata, e.wdata);
            end
        end
        if (if_valid || dm_valid) begin
            if (rsp_q.size() == 0) begin
                chk("valid_unexpected", 32'({if_valid, dm_valid}), 32'h0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_owner", 32'({if_valid, dm_valid}), r.is_dm ? 32'h1 : 32'h2);
                chk("rsp_data", r.is_dm ? dm_rdata : if_rdata, r.data);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic want_dm, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (want_dm ? dm_valid : if_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 load+store (behaves as a store)
    task automatic do_access(input vec_t v, output int lat, output int stall_bad, output logic stall_at_v);
        int t;
        logic we;
        t = cyc;
        we = (v.kind >= 2);
        if (v.kind == 0) begin
            if_req = 1'b1; if_addr = v.addr;
            mreq_q.push_back('{1'b0, v.addr, 32'h0});
            rsp_q.push_back('{1'b0, mem_word(v.addr)});
        end else begin
            dm_read = (v.kind == 1 || v.kind == 3); dm_write = we;
            dm_addr = v.addr; dm_wdata = v.wdata;
            mreq_q.push_back('{we, v.addr, v.wdata});
            if (!we) exp_dm = mem_word(v.addr);
            rsp_q.push_back('{1'b1, exp_dm});
        end
        flush_if = (v.flush_at == 0);
        lat = -1; stall_bad = 0; stall_at_v = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (v.kind == 0 ? if_valid : dm_valid) begin
                lat = cyc - t;
                stall_at_v = (v.kind == 0) ? if_stall : dm_stall;
                break;
            end
            if (!((v.kind == 0) ? if_stall : dm_stall)) stall_bad++;
            next_cyc();
            flush_if = (k + 1 == v.flush_at);
        end
        next_cyc();
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; flush_if = 1'b0;
    endtask

    initial begin
        int t, at, at2, lat, sb, a1, a7;
        logic sv;

        vecs[0] = '{0, 32'h40,  32'h0,        -1, 32'h00500093,      LAT + 2};
        vecs[1] = '{1, 32'h100, 32'h0,         2, 32'hDEADBEEF,      LAT + 2};
        vecs[2] = '{2, 32'h104, 32'h12345678, -1, 32'hDEADBEEF,      LAT + 2};
        vecs[3] = '{3, 32'h108, 32'hCAFEF00D, -1, 32'hDEADBEEF,      LAT + 2};
        vecs[4] = '{0, 32'h80,  32'h0,         0, mem_word(32'h80),  LAT + 2};
        vecs[5] = '{1, 32'h200, 32'h0,        -1, mem_word(32'h200), LAT + 2};

        // Reset values
        if_req = 1'b1;
        #2;
        chk("rst_ctl", 32'({m_en, m_we, if_valid, dm_valid}), 32'h0);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_data", m_wdata | if_rdata | dm_rdata, 32'h0);
        chk("rst_stall", 32'({if_stall, dm_stall}), 32'h2);
        if_req = 1'b0;
        repeat (2) next_cyc();
        arst_n = 1'b1;
        next_cyc();

        // Vector table: one isolated access each
        foreach (vecs[i]) begin
            do_access(vecs[i], lat, sb, sv);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_stall_wait", i), 32'(sb), 32'h0);
            chk($sformatf("vec%0d_stall_at_valid", i), 32'(sv), 32'h0);
            chk($sformatf("vec%0d_rdata", i), vecs[i].kind == 0 ? if_rdata : dm_rdata, vecs[i].exp_rdata);
            next_cyc();
        end

        // Simultaneous fetch and load: load first, fetch re-arbitrated afterwards
        t = cyc;
        if_req = 1'b1; if_addr = 32'h44; dm_read = 1'b1; dm_addr = 32'h100;
        mreq_q.push_back('{1'b0, 32'h100, 32'h0});
        mreq_q.push_back('{1'b0, 32'h44, 32'h0});
        exp_dm = 32'hDEADBEEF;
        rsp_q.push_back('{1'b1, 32'hDEADBEEF});
        rsp_q.push_back('{1'b0, mem_word(32'h44)});
        wait_valid(1'b1, 20, at);
        chk("both_dm_lat", 32'(at - t), 32'h4);
        chk("both_if_stall_during_dm", 32'(if_stall), 32'h1);
        next_cyc();
        dm_read = 1'b0;
        wait_valid(1'b0, 20, at2);
        chk("both_if_lat", 32'(at2 - t), 32'h9);
        chk("both_if_issue", 32'(last_men - t), 32'h6);
        next_cyc();
        if_req = 1'b0;
        repeat (2) next_cyc();

        // Flush during WAIT, then redirected fetch
        t = cyc;
        if_req = 1'b1; if_addr = 32'h48;
        mreq_q.push_back('{1'b0, 32'h48, 32'h0});
        next_cyc();
        next_cyc();
        flush_if = 1'b1;
        next_cyc();
        flush_if = 1'b0;
        @(negedge clk);
        chk("flush_stall_t3", 32'({if_stall, if_valid}), 32'h2);
        next_cyc();
        @(negedge clk);
        chk("flush_stall_done", 32'({if_stall, if_valid}), 32'h2);
        chk("flush_rdata_updated", if_rdata, mem_word(32'h48));
        next_cyc();
        if_addr = 32'h80;
        mreq_q.push_back('{1'b0, 32'h80, 32'h0});
        rsp_q.push_back('{1'b0, mem_word(32'h80)});
        wait_valid(1'b0, 20, at);
        chk("flush_redirect_lat", 32'(at - t), 32'h9);
        chk("flush_redirect_issue", 32'(last_men - t), 32'h6);
        next_cyc();
        if_req = 1'b0;
        repeat (2) next_cyc();

        // Load withdrawn before completion: runs internally, no valid
        dm_read = 1'b1; dm_addr = 32'h300;
        mreq_q.push_back('{1'b0, 32'h300, 32'h0});
        exp_dm = mem_word(32'h300);
        next_cyc();
        next_cyc();
        dm_read = 1'b0;
        repeat (5) next_cyc();
        chk("withdraw_rdata", dm_rdata, exp_dm);
        chk("withdraw_stall", 32'(dm_stall), 32'h0);

        // Asynchronous reset while an access is in flight
        dm_read = 1'b1; dm_addr = 32'h400;
        next_cyc();
        chk("midrst_men_before", 32'(m_en), 32'h1);
        arst_n = 1'b0; dm_read = 1'b0;
        #1;
        chk("midrst_ctl", 32'({m_en, m_we, if_valid, dm_valid}), 32'h0);
        chk("midrst_maddr", m_addr, 32'h0);
        chk("midrst_rdata", if_rdata | dm_rdata, 32'h0);
        next_cyc();
        arst_n = 1'b1;
        repeat (10) next_cyc();
        chk("midrst_rdata_after", dm_rdata, 32'h0);

        // Latency extremes
        t = cyc; a1 = -1; a7 = -1;
        l1_req = 1'b1; l7_req = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (l1_valid && a1 < 0) begin
                a1 = cyc - t;
                chk("lat1_rdata", l1_rdata, 32'h00500093);
            end
            if (l7_valid && a7 < 0) begin
                a7 = cyc - t;
                chk("lat7_rdata", l7_rdata, 32'h00500093);
            end
            if (a1 >= 0 && a7 >= 0) break;
            next_cyc();
            if (a1 >= 0) l1_req = 1'b0;
            if (a7 >= 0) l7_req = 1'b0;
        end
        l1_req = 1'b0; l7_req = 1'b0;
        chk("lat1_valid", 32'(a1), 32'h3);
        chk("lat7_valid", 32'(a7), 32'h9);
        repeat (3) next_cyc();

        chk("mreq_q_empty", 32'(mreq_q.size()), 32'h0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
